// File: rtl/uart_txsm_gen.sv
// UART transmit state machine: pops words from an external Tx FIFO and frames them as
// start/data/parity/stop on TxD, with break generation and RS-485 DE lead/tail timing.
module uart_txsm_gen #(
  parameter int DATA_W  = 9,
  parameter int OVS     = 16,
  parameter int DE_LEAD = 0,
  parameter int DE_TAIL = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              CE_16x,
  input  logic [3:0]        Len,
  input  logic [1:0]        NumStop,
  input  logic              ParEn,
  input  logic [1:0]        Par,
  input  logic              Brk,
  input  logic              TF_EF,
  input  logic [DATA_W-1:0] THR,
  input  logic              CTSi,
  output logic              TF_RE,
  output logic              TxD,
  output logic              DE,
  output logic              TxIdle,
  output logic              TxStart,
  output logic              TxShift,
  output logic              TxStop
);

  localparam int CMAX1 = (DE_LEAD > 2*OVS) ? DE_LEAD : 2*OVS;
  localparam int CMAX  = (DE_TAIL > CMAX1) ? DE_TAIL : CMAX1;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0] BIT_END  = CW'(OVS - 1);
  localparam logic [CW-1:0] LEAD_END = CW'((DE_LEAD > 0) ? DE_LEAD - 1 : 0);
  localparam logic [CW-1:0] TAIL_END = CW'((DE_TAIL > 0) ? DE_TAIL - 1 : 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BRK    = 3'd1;
  localparam logic [2:0] S_LEAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_SHIFT  = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;
  localparam logic [2:0] S_TAIL   = 3'd7;

  logic [2:0]        state, state_n;
  logic [CW-1:0]     cnt, cnt_n, stop_end;
  logic [3:0]        bit_cnt, bit_n, len_q, len_n, len_c;
  logic [DATA_W-1:0] shreg, sh_n;
  logic [1:0]        stop_q, stop_n;
  logic              par_en_q, par_en_n, par_bit_q, par_bit_n, par_c;
  logic              brk_mark, mark_n, txd_n, load, go;

  assign go = ~TF_EF & CTSi & ~Brk;

  // Frame format as it will be latched: clamped length and the parity bit over those bits only.
  always_comb begin
    logic ones;
    len_c = Len;
    if (Len < 4'd5) len_c = 4'd5;
    else if (int'(Len) > DATA_W) len_c = 4'(DATA_W);
    ones = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (i < int'(len_c)) ones = ones ^ THR[i];
    case (Par)
      2'b00:   par_c = ~ones;
      2'b01:   par_c = ones;
      2'b10:   par_c = 1'b0;
      default: par_c = 1'b1;
    endcase
  end

  always_comb begin
    case (stop_q)
      2'b00:   stop_end = BIT_END;
      2'b01:   stop_end = CW'(3*OVS/2 - 1);
      default: stop_end = CW'(2*OVS - 1);
    endcase
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_cnt;
    sh_n      = shreg;
    len_n     = len_q;
    stop_n    = stop_q;
    par_en_n  = par_en_q;
    par_bit_n = par_bit_q;
    mark_n    = brk_mark;
    txd_n     = TxD;
    load      = 1'b0;
    if (CE_16x) begin
      cnt_n = cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt_n = '0;
          if (Brk) begin
            state_n = S_BRK;
            txd_n   = 1'b0;
            mark_n  = 1'b0;
          end else if (go) begin
            if (DE_LEAD > 0) begin
              state_n = S_LEAD;
              txd_n   = 1'b1;
            end else begin
              load = 1'b1;
            end
          end
        end
        // Break holds the line low, then guarantees one full mark bit before idling.
        S_BRK: begin
          if (!brk_mark) begin
            cnt_n = '0;
            if (!Brk) begin
              mark_n = 1'b1;
              txd_n  = 1'b1;
            end
          end else if (cnt == BIT_END) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            mark_n  = 1'b0;
          end
        end
        S_LEAD: if (cnt == LEAD_END) load = 1'b1;
        S_START: begin
          if (cnt == BIT_END) begin
            state_n = S_SHIFT;
            cnt_n   = '0;
            txd_n   = shreg[0];
            sh_n    = shreg >> 1;
            bit_n   = 4'd1;
          end
        end
        S_SHIFT: begin
          if (cnt == BIT_END) begin
            cnt_n = '0;
            if (bit_cnt == len_q) begin
              state_n = par_en_q ? S_PARITY : S_STOP;
              txd_n   = par_en_q ? par_bit_q : 1'b1;
            end else begin
              txd_n = shreg[0];
              sh_n  = shreg >> 1;
              bit_n = bit_cnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (cnt == BIT_END) begin
            state_n = S_STOP;
            cnt_n   = '0;
            txd_n   = 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == stop_end) begin
            cnt_n = '0;
            if (go) load = 1'b1;
            else state_n = (DE_TAIL > 0) ? S_TAIL : S_IDLE;
          end
        end
        default: begin
          if (go) load = 1'b1;
          else if (cnt == TAIL_END) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end
        end
      endcase
      if (load) begin
        state_n   = S_START;
        cnt_n     = '0;
        txd_n     = 1'b0;
        sh_n      = THR;
        len_n     = len_c;
        stop_n    = NumStop;
        par_en_n  = ParEn;
        par_bit_n = par_c;
      end
    end
  end

  // Status outputs are registered from the next state so they line up with TxD.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      len_q     <= '0;
      stop_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      brk_mark  <= 1'b0;
      TxD       <= 1'b1;
      DE        <= 1'b0;
      TF_RE     <= 1'b0;
      TxIdle    <= 1'b1;
      TxStart   <= 1'b0;
      TxShift   <= 1'b0;
      TxStop    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_n;
      shreg     <= sh_n;
      len_q     <= len_n;
      stop_q    <= stop_n;
      par_en_q  <= par_en_n;
      par_bit_q <= par_bit_n;
      brk_mark  <= mark_n;
      TxD       <= txd_n;
      DE        <= (state_n != S_IDLE);
      TF_RE     <= load;
      TxIdle    <= (state_n == S_IDLE);
      TxStart   <= (state_n == S_START);
      TxShift   <= (state_n == S_SHIFT) || (state_n == S_PARITY);
      TxStop    <= (state_n == S_STOP);
    end
  end

endmodule
